// File: rtl/ysyx_idu_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_idu_stage_if                                               |
// | Purpose  : Handshake and control-bundle bus between IFU, IDU stage and EXU.|
// |            master = IFU/EXU side (drives in_*, out_ready),                 |
// |            slave  = decode stage (drives in_ready, out_*, count).          |
// | Ports    : in_valid/in_ready/in_inst/in_pc      IFU -> stage handshake    |
// |            out_valid/out_ready/out_*             stage -> EXU bundle       |
// |            count                                 FIFO occupancy            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface ysyx_idu_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_inst;
  logic [ADDR_W-1:0]        in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_pc;
  logic [4:0]               out_rd;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic [31:0]              out_imm;
  logic                     out_rf_wr_en;
  logic                     out_csr_wr_en;
  logic                     out_do_jump;
  logic                     out_alu_a_sel;
  logic                     out_alu_b_sel;
  logic [2:0]               out_rf_wr_sel;
  logic [2:0]               out_br_type;
  logic [4:0]               out_alu_ctrl;
  logic [2:0]               out_dm_rd_sel;
  logic [1:0]               out_dm_wr_sel;
  logic                     out_is_ecall;
  logic                     out_is_mret;
  logic                     out_is_ebreak;
  logic                     out_illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_rf_wr_en, out_csr_wr_en, out_do_jump, out_alu_a_sel, out_alu_b_sel,
           out_rf_wr_sel, out_br_type, out_alu_ctrl, out_dm_rd_sel, out_dm_wr_sel,
           out_is_ecall, out_is_mret, out_is_ebreak, out_illegal, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_rf_wr_en, out_csr_wr_en, out_do_jump, out_alu_a_sel, out_alu_b_sel,
           out_rf_wr_sel, out_br_type, out_alu_ctrl, out_dm_rd_sel, out_dm_wr_sel,
           out_is_ecall, out_is_mret, out_is_ebreak, out_illegal, count
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_idu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ysyx_idu_stage                                                  |
// | Purpose  : RV32I/E(+M) decode stage. Decodes in_inst/in_pc into a control  |
// |            bundle, flags illegal encodings and ebreak, and buffers the     |
// |            result in a DEPTH-entry valid/ready FIFO with flush.            |
// | Ports    : clk    rising-edge clock                                        |
// |            rst_n  asynchronous active-low reset                            |
// |            flush  synchronous flush, empties the FIFO on the next edge     |
// |            bus    ysyx_idu_stage_if.slave (IFU handshake, EXU bundle)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ysyx_idu_stage #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2,
  parameter int HAS_M  = 0,
  parameter int RV32E  = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         flush,
  ysyx_idu_stage_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  localparam logic [6:0] c_op_lui    = 7'h37;
  localparam logic [6:0] c_op_auipc  = 7'h17;
  localparam logic [6:0] c_op_jal    = 7'h6f;
  localparam logic [6:0] c_op_jalr   = 7'h67;
  localparam logic [6:0] c_op_branch = 7'h63;
  localparam logic [6:0] c_op_load   = 7'h03;
  localparam logic [6:0] c_op_store  = 7'h23;
  localparam logic [6:0] c_op_imm    = 7'h13;
  localparam logic [6:0] c_op_reg    = 7'h33;
  localparam logic [6:0] c_op_system = 7'h73;

  localparam logic [31:0] c_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_ebreak = 32'h0010_0073;
  localparam logic [31:0] c_mret   = 32'h3020_0073;

  localparam logic [2:0] c_wb_pc4 = 3'd1;
  localparam logic [2:0] c_wb_alu = 3'd2;
  localparam logic [2:0] c_wb_mem = 3'd3;
  localparam logic [2:0] c_wb_csr = 3'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              rf_wr_en;
    logic              csr_wr_en;
    logic              do_jump;
    logic              alu_a_sel;
    logic              alu_b_sel;
    logic [2:0]        rf_wr_sel;
    logic [2:0]        br_type;
    logic [4:0]        alu_ctrl;
    logic [2:0]        dm_rd_sel;
    logic [1:0]        dm_wr_sel;
    logic              is_ecall;
    logic              is_mret;
    logic              is_ebreak;
    logic              illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [31:0] w_inst;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_inst  = bus.in_inst;
  assign w_op    = w_inst[6:0];
  assign w_f3    = w_inst[14:12];
  assign w_f7    = w_inst[31:25];
  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'd0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  entry_t w_raw;
  entry_t w_entry;
  logic   w_known;
  logic   w_use_rd, w_use_rs1, w_use_rs2;
  logic   w_reg_bad;

  always_comb begin
    w_raw           = '0;
    w_raw.pc        = bus.in_pc;
    w_raw.rd        = w_inst[11:7];
    w_raw.rs1       = w_inst[19:15];
    w_raw.rs2       = w_inst[24:20];
    w_raw.alu_b_sel = 1'b1;
    w_known         = 1'b0;
    w_use_rd        = 1'b0;
    w_use_rs1       = 1'b0;
    w_use_rs2       = 1'b0;
    case (w_op)
      c_op_lui, c_op_auipc: begin
        w_known         = 1'b1;
        w_use_rd        = 1'b1;
        w_raw.imm       = w_imm_u;
        w_raw.alu_ctrl  = (w_op == c_op_lui) ? 5'd14 : 5'd0;
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_alu;
      end
      c_op_jal: begin
        w_known         = 1'b1;
        w_use_rd        = 1'b1;
        w_raw.imm       = w_imm_j;
        w_raw.do_jump   = 1'b1;
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_pc4;
      end
      c_op_jalr: begin
        w_known         = (w_f3 == 3'd0);
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_raw.imm       = w_imm_i;
        w_raw.alu_a_sel = 1'b1;
        w_raw.do_jump   = 1'b1;
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_pc4;
      end
      c_op_branch: begin
        // funct3 010/011 are the only unassigned branch encodings
        w_known       = (w_f3[2:1] != 2'b01);
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
        w_raw.imm     = w_imm_b;
        w_raw.br_type = w_f3[2] ? w_f3 : {2'b01, w_f3[0]};
      end
      c_op_load: begin
        w_known         = 1'b1;
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_raw.imm       = w_imm_i;
        w_raw.alu_a_sel = 1'b1;
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_mem;
        case (w_f3)
          3'b000:  w_raw.dm_rd_sel = 3'd1;
          3'b100:  w_raw.dm_rd_sel = 3'd2;
          3'b001:  w_raw.dm_rd_sel = 3'd3;
          3'b101:  w_raw.dm_rd_sel = 3'd4;
          3'b010:  w_raw.dm_rd_sel = 3'd5;
          default: w_known = 1'b0;
        endcase
      end
      c_op_store: begin
        w_known         = (w_f3 <= 3'd2);
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_raw.imm       = w_imm_s;
        w_raw.alu_a_sel = 1'b1;
        w_raw.dm_wr_sel = w_f3[1:0] + 2'd1;
      end
      c_op_imm: begin
        // shifts carry funct7 in the immediate; only slli/srli/srai patterns exist
        case (w_f3)
          3'b001:  w_known = (w_f7 == 7'h00);
          3'b101:  w_known = (w_f7 == 7'h00) || (w_f7 == 7'h20);
          default: w_known = 1'b1;
        endcase
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_raw.imm       = w_imm_i;
        w_raw.alu_a_sel = 1'b1;
        w_raw.alu_ctrl  = (w_f3 == 3'b101 && w_f7[5]) ? 5'd13 : {2'b00, w_f3};
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_alu;
      end
      c_op_reg: begin
        w_use_rd        = 1'b1;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_raw.alu_a_sel = 1'b1;
        w_raw.alu_b_sel = 1'b0;
        w_raw.rf_wr_en  = 1'b1;
        w_raw.rf_wr_sel = c_wb_alu;
        case (w_f7)
          7'h00: begin
            w_known        = 1'b1;
            w_raw.alu_ctrl = {2'b00, w_f3};
          end
          7'h20: begin
            w_known        = (w_f3 == 3'b000) || (w_f3 == 3'b101);
            w_raw.alu_ctrl = (w_f3 == 3'b000) ? 5'd8 : 5'd13;
          end
          7'h01: begin
            w_known        = (HAS_M != 0);
            w_raw.alu_ctrl = {2'b10, w_f3};
          end
          default: w_known = 1'b0;
        endcase
      end
      c_op_system: begin
        w_raw.imm = w_imm_i;
        if (w_inst == c_ecall) begin
          w_known        = 1'b1;
          w_raw.is_ecall = 1'b1;
        end else if (w_inst == c_ebreak) begin
          w_known         = 1'b1;
          w_raw.is_ebreak = 1'b1;
        end else if (w_inst == c_mret) begin
          w_known       = 1'b1;
          w_raw.is_mret = 1'b1;
        end else if (w_f3 == 3'b001 || w_f3 == 3'b010) begin
          w_known         = 1'b1;
          w_use_rd        = 1'b1;
          w_use_rs1       = 1'b1;
          w_raw.rf_wr_en  = 1'b1;
          w_raw.csr_wr_en = 1'b1;
          w_raw.rf_wr_sel = c_wb_csr;
        end
      end
      default: w_known = 1'b0;
    endcase
  end

  // RV32E only has x0..x15, so any referenced index with bit 4 set is illegal
  assign w_reg_bad = (RV32E != 0) &&
                     ((w_use_rd  && w_raw.rd[4])  ||
                      (w_use_rs1 && w_raw.rs1[4]) ||
                      (w_use_rs2 && w_raw.rs2[4]));

  // Illegal entries keep only pc and raw register fields so the EXU sees no side effects
  always_comb begin
    w_entry = w_raw;
    if (!w_known || w_reg_bad) begin
      w_entry         = '0;
      w_entry.pc      = w_raw.pc;
      w_entry.rd      = w_raw.rd;
      w_entry.rs1     = w_raw.rs1;
      w_entry.rs2     = w_raw.rs2;
      w_entry.illegal = 1'b1;
    end
  end

  // ------------------------------------------------------------------ FIFO
  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop, w_not_empty;
  entry_t           w_head;

  assign w_not_empty  = (r_count != '0);
  assign bus.in_ready = (r_count != c_full);
  assign w_push       = bus.in_valid && bus.in_ready && !flush;
  assign w_pop        = w_not_empty && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; gating by occupancy keeps every output at 0 when empty
  assign w_head = w_not_empty ? r_mem[r_rd_ptr] : '0;

  assign bus.out_valid     = w_not_empty;
  assign bus.count         = r_count;
  assign bus.out_pc        = w_head.pc;
  assign bus.out_rd        = w_head.rd;
  assign bus.out_rs1       = w_head.rs1;
  assign bus.out_rs2       = w_head.rs2;
  assign bus.out_imm       = w_head.imm;
  assign bus.out_rf_wr_en  = w_head.rf_wr_en;
  assign bus.out_csr_wr_en = w_head.csr_wr_en;
  assign bus.out_do_jump   = w_head.do_jump;
  assign bus.out_alu_a_sel = w_head.alu_a_sel;
  assign bus.out_alu_b_sel = w_head.alu_b_sel;
  assign bus.out_rf_wr_sel = w_head.rf_wr_sel;
  assign bus.out_br_type   = w_head.br_type;
  assign bus.out_alu_ctrl  = w_head.alu_ctrl;
  assign bus.out_dm_rd_sel = w_head.dm_rd_sel;
  assign bus.out_dm_wr_sel = w_head.dm_wr_sel;
  assign bus.out_is_ecall  = w_head.is_ecall;
  assign bus.out_is_mret   = w_head.is_mret;
  assign bus.out_is_ebreak = w_head.is_ebreak;
  assign bus.out_illegal   = w_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_idu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ysyx_idu_stage                                               |
// | Purpose  : Self-checking bench for ysyx_idu_stage. Two instances share the |
// |            same stimulus: dut0 (HAS_M=0, RV32E=0) and dut1 (HAS_M=1,       |
// |            RV32E=1). A queue-based reference model tracks FIFO contents.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ysyx_idu_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rf_wr_en;
    logic        csr_wr_en;
    logic        do_jump;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [2:0]  rf_wr_sel;
    logic [2:0]  br_type;
    logic [4:0]  alu_ctrl;
    logic [2:0]  dm_rd_sel;
    logic [1:0]  dm_wr_sel;
    logic        is_ecall;
    logic        is_mret;
    logic        is_ebreak;
    logic        illegal;
  } bund_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  alu0;
    logic        ill0;
    logic [4:0]  alu1;
    logic        ill1;
    logic        rfwr0;
    logic [31:0] imm0;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  int passed = 0;
  int total  = 0;
  logic [63:0] q [$];   // {inst, pc} of accepted, not yet consumed instructions

  always #5 clk = ~clk;

  ysyx_idu_stage_if #(.ADDR_W(32), .DEPTH(DEPTH)) bus0 ();
  ysyx_idu_stage_if #(.ADDR_W(32), .DEPTH(DEPTH)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_inst   = in_inst;
  assign bus0.in_pc     = in_pc;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_inst   = in_inst;
  assign bus1.in_pc     = in_pc;
  assign bus1.out_ready = out_ready;

  ysyx_idu_stage #(.ADDR_W(32), .DEPTH(DEPTH), .HAS_M(0), .RV32E(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0.slave));
  ysyx_idu_stage #(.ADDR_W(32), .DEPTH(DEPTH), .HAS_M(1), .RV32E(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1.slave));

  bund_t act0, act1;
  assign act0 = {bus0.out_pc, bus0.out_rd, bus0.out_rs1, bus0.out_rs2, bus0.out_imm,
                 bus0.out_rf_wr_en, bus0.out_csr_wr_en, bus0.out_do_jump, bus0.out_alu_a_sel,
                 bus0.out_alu_b_sel, bus0.out_rf_wr_sel, bus0.out_br_type, bus0.out_alu_ctrl,
                 bus0.out_dm_rd_sel, bus0.out_dm_wr_sel, bus0.out_is_ecall, bus0.out_is_mret,
                 bus0.out_is_ebreak, bus0.out_illegal};
  assign act1 = {bus1.out_pc, bus1.out_rd, bus1.out_rs1, bus1.out_rs2, bus1.out_imm,
                 bus1.out_rf_wr_en, bus1.out_csr_wr_en, bus1.out_do_jump, bus1.out_alu_a_sel,
                 bus1.out_alu_b_sel, bus1.out_rf_wr_sel, bus1.out_br_type, bus1.out_alu_ctrl,
                 bus1.out_dm_rd_sel, bus1.out_dm_wr_sel, bus1.out_is_ecall, bus1.out_is_mret,
                 bus1.out_is_ebreak, bus1.out_illegal};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decode from the ISA tables: mnemonic -> control bundle
  function automatic bund_t model(input logic [31:0] inst, input logic [31:0] pc,
                                  input bit has_m, input bit e);
    bund_t b;
    bit ok, urd, urs1, urs2;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii, is, ib, iu, ij;
    logic [2:0] ld_map [8];
    ld_map = '{3'd1, 3'd3, 3'd5, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0};
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    ii = $signed(inst[31:20]);
    is = $signed({inst[31:25], inst[11:7]});
    ib = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    iu = {inst[31:12], 12'd0};
    ij = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    b = '0; b.pc = pc; b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
    b.alu_b_sel = 1; ok = 0; urd = 0; urs1 = 0; urs2 = 0;
    if (op == 7'h37 || op == 7'h17) begin
      ok = 1; urd = 1; b.imm = iu; b.alu_ctrl = (op == 7'h37) ? 14 : 0;
      b.rf_wr_en = 1; b.rf_wr_sel = 2;
    end else if (op == 7'h6f) begin
      ok = 1; urd = 1; b.imm = ij; b.do_jump = 1; b.rf_wr_en = 1; b.rf_wr_sel = 1;
    end else if (op == 7'h67 && f3 == 0) begin
      ok = 1; urd = 1; urs1 = 1; b.imm = ii; b.alu_a_sel = 1; b.do_jump = 1;
      b.rf_wr_en = 1; b.rf_wr_sel = 1;
    end else if (op == 7'h63 && f3 != 2 && f3 != 3) begin
      ok = 1; urs1 = 1; urs2 = 1; b.imm = ib; b.br_type = (f3 < 2) ? f3 + 2 : f3;
    end else if (op == 7'h03 && ld_map[f3] != 0) begin
      ok = 1; urd = 1; urs1 = 1; b.imm = ii; b.alu_a_sel = 1; b.rf_wr_en = 1;
      b.rf_wr_sel = 3; b.dm_rd_sel = ld_map[f3];
    end else if (op == 7'h23 && f3 < 3) begin
      ok = 1; urs1 = 1; urs2 = 1; b.imm = is; b.alu_a_sel = 1; b.dm_wr_sel = 2'(f3 + 1);
    end else if (op == 7'h13) begin
      ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
      urd = 1; urs1 = 1; b.imm = ii; b.alu_a_sel = 1; b.rf_wr_en = 1; b.rf_wr_sel = 2;
      b.alu_ctrl = (f3 == 5 && f7 == 7'h20) ? 13 : 5'(f3);
    end else if (op == 7'h33) begin
      urd = 1; urs1 = 1; urs2 = 1; b.alu_a_sel = 1; b.alu_b_sel = 0;
      b.rf_wr_en = 1; b.rf_wr_sel = 2;
      if (f7 == 0) begin ok = 1; b.alu_ctrl = 5'(f3); end
      else if (f7 == 7'h20 && f3 == 0) begin ok = 1; b.alu_ctrl = 8; end
      else if (f7 == 7'h20 && f3 == 5) begin ok = 1; b.alu_ctrl = 13; end
      else if (f7 == 1 && has_m) begin ok = 1; b.alu_ctrl = 5'(16 + f3); end
    end else if (op == 7'h73) begin
      b.imm = ii;
      if (inst == 32'h00000073) begin ok = 1; b.is_ecall = 1; end
      else if (inst == 32'h00100073) begin ok = 1; b.is_ebreak = 1; end
      else if (inst == 32'h30200073) begin ok = 1; b.is_mret = 1; end
      else if (f3 == 1 || f3 == 2) begin
        ok = 1; urd = 1; urs1 = 1; b.rf_wr_en = 1; b.csr_wr_en = 1; b.rf_wr_sel = 4;
      end
    end
    if (e && ((urd && b.rd >= 16) || (urs1 && b.rs1 >= 16) || (urs2 && b.rs2 >= 16))) ok = 0;
    if (!ok) begin
      b = '0; b.pc = pc; b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
      b.illegal = 1;
    end
    return b;
  endfunction

  task automatic check_state();
    bund_t e0, e1;
    e0 = '0; e1 = '0;
    if (q.size() > 0) begin
      e0 = model(q[0][63:32], q[0][31:0], 0, 0);
      e1 = model(q[0][63:32], q[0][31:0], 1, 1);
    end
    chk("count0",  128'(bus0.count), 128'(q.size()));
    chk("ready0",  128'(bus0.in_ready), 128'(q.size() != DEPTH));
    chk("valid0",  128'(bus0.out_valid), 128'(q.size() != 0));
    chk("bundle0", 128'(act0), 128'(e0));
    chk("count1",  128'(bus1.count), 128'(q.size()));
    chk("bundle1", 128'(act1), 128'(e1));
  endtask

  // One cycle: drive at negedge, check registered state, apply edge to model
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    bit do_push, do_pop;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    check_state();
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() > 0) && rdy && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({inst, pc});
    end
    @(negedge clk);
  endtask

  vec_t tbl [13];

  initial begin
    logic [31:0] r, base;
    int k;
    tbl[0]  = '{32'h00500093, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 32'h00000005}; // addi x1,x0,5
    tbl[1]  = '{32'h022081B3, 5'd0,  1'b1, 5'd16, 1'b0, 1'b0, 32'h00000000}; // mul
    tbl[2]  = '{32'h00208833, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 32'h00000000}; // add x16
    tbl[3]  = '{32'h00100073, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h00000001}; // ebreak
    tbl[4]  = '{32'h123452B7, 5'd14, 1'b0, 5'd14, 1'b0, 1'b1, 32'h12345000}; // lui
    tbl[5]  = '{32'h402081B3, 5'd8,  1'b0, 5'd8,  1'b0, 1'b1, 32'h00000000}; // sub
    tbl[6]  = '{32'h4030D093, 5'd13, 1'b0, 5'd13, 1'b0, 1'b1, 32'h00000403}; // srai
    tbl[7]  = '{32'hFE208EE3, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'hFFFFFFFC}; // beq -4
    tbl[8]  = '{32'h0220C1B3, 5'd0,  1'b1, 5'd20, 1'b0, 1'b0, 32'h00000000}; // div
    tbl[9]  = '{32'h300110F3, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 32'h00000300}; // csrrw
    tbl[10] = '{32'h0000000B, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 32'h00000000}; // bad opcode
    tbl[11] = '{32'h008000EF, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 32'h00000008}; // jal x1,8
    tbl[12] = '{32'h0020A423, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'h00000008}; // sw

    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state and table vectors: push, check head one cycle later, pop
    for (int i = 0; i < 13; i++) begin
      step(1, tbl[i].inst, 32'h8000_0000 + 32'(i * 4), 1, 0);
      chk($sformatf("tbl%0d_alu0", i), 128'(bus0.out_alu_ctrl), 128'(tbl[i].alu0));
      chk($sformatf("tbl%0d_ill0", i), 128'(bus0.out_illegal),  128'(tbl[i].ill0));
      chk($sformatf("tbl%0d_alu1", i), 128'(bus1.out_alu_ctrl), 128'(tbl[i].alu1));
      chk($sformatf("tbl%0d_ill1", i), 128'(bus1.out_illegal),  128'(tbl[i].ill1));
      chk($sformatf("tbl%0d_rfwr0", i), 128'(bus0.out_rf_wr_en), 128'(tbl[i].rfwr0));
      chk($sformatf("tbl%0d_imm0", i), 128'(bus0.out_imm),      128'(tbl[i].imm0));
      step(0, 0, 0, 1, 0);
    end

    // full: three pushes with out_ready low, third is refused
    step(1, tbl[0].inst, 32'h100, 0, 0);
    step(1, tbl[4].inst, 32'h104, 0, 0);
    chk("full_count", 128'(bus0.count), 128'(2));
    chk("full_ready", 128'(bus0.in_ready), 128'(0));
    step(1, tbl[5].inst, 32'h108, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("order_pc", 128'(bus0.out_pc), 128'(32'h104));
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // simultaneous push/pop at count=1, pointers wrap several times
    step(1, tbl[6].inst, 32'h200, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].inst, 32'h204 + 32'(i * 4), 1, 0);
      chk("pp_count", 128'(bus0.count), 128'(1));
    end
    step(0, 0, 0, 1, 0);

    // flush with full FIFO and in_valid high
    step(1, tbl[1].inst, 32'h300, 0, 0);
    step(1, tbl[2].inst, 32'h304, 0, 0);
    step(1, tbl[3].inst, 32'h308, 1, 1);
    chk("flush_count", 128'(bus0.count), 128'(0));
    chk("flush_valid", 128'(bus0.out_valid), 128'(0));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      k = $urandom_range(0, 12);
      base = tbl[k].inst;
      case ($urandom_range(0, 3))
        0, 1: in_inst = (base & ~32'h01FF8F80) | (r & 32'h01FF8F80);
        2:    in_inst = base;
        default: in_inst = r;
      endcase
      step($urandom_range(0, 3) != 0, in_inst, {$urandom} & 32'hFFFF_FFFC,
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // asynchronous reset mid-stream
    step(1, tbl[0].inst, 32'h400, 0, 0);
    step(1, tbl[4].inst, 32'h404, 0, 0);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(bus0.out_valid), 128'(0));
    chk("arst_count", 128'(bus0.count), 128'(0));
    chk("arst_ready", 128'(bus0.in_ready), 128'(1));
    chk("arst_bundle", 128'(act0), 128'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    step(1, tbl[9].inst, 32'h500, 1, 0);
    step(0, 0, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_idu_stage.md
Name: ysyx_idu_stage

Overview:
- Pipelined, parametrised RV32I/E(+M) decode stage between IFU and EXU.
- Decodes an incoming instruction/PC pair into a control bundle.
- Buffers the bundle in a DEPTH-entry FIFO with valid/ready on both sides.
- Adds three things the single-cycle decoder lacks: illegal-instruction detection, an ebreak flag output (no DPI call inside), and flush.

Parameters:
- ADDR_W, 32, width of pc.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- HAS_M, 0, 1 = decode RV32M (op 0x33, funct7 0x01); 0 = such encodings are illegal.
- RV32E, 0, 1 = any used rs1/rs2/rd index ≥16 is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept; equals !full.
- in_inst  in  32  instruction word.
- in_pc  in  ADDR_W  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  EXU consumes head.
- out_pc  out  ADDR_W  PC of head entry.
- out_rd, out_rs1, out_rs2  out  5 each  register indices, inst[11:7], [19:15], [24:20].
- out_imm  out  32  sign-extended immediate (I/S/B/U/J by format; 0 for R).
- out_rf_wr_en, out_csr_wr_en, out_do_jump, out_alu_a_sel, out_alu_b_sel  out  1 each  control bits.
- out_rf_wr_sel  out  3  0 none, 1 pc+4, 2 alu, 3 mem, 4 csr.
- out_br_type  out  3  0 none, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
- out_alu_ctrl  out  5  see Behaviour.
- out_dm_rd_sel  out  3  1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, else 0.
- out_dm_wr_sel  out  2  1 sb, 2 sh, 3 sw, else 0.
- out_is_ecall, out_is_mret, out_is_ebreak, out_illegal  out  1 each  system/exception flags.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:

Decode (combinational on input side):
- alu_ctrl: 0 add (auipc, jal, jalr, loads, stores, branches, add, addi), 1 sll, 2 slt, 3 sltu/sltiu, 4 xor, 5 srl, 6 or, 7 and, 8 sub, 13 sra, 14 pass-B (lui).
- alu_ctrl, HAS_M=1 only: 16 mul, 17 mulh, 18 mulhsu, 19 mulhu, 20 div, 21 divu, 22 rem, 23 remu.
- alu_a_sel = 1 for I, R, S formats.
- alu_b_sel = 0 only for R format (including M).
- rf_wr_en for I, U, J, R, csrrw, csrrs.
- csr_wr_en for csrrw, csrrs.
- do_jump for jal, jalr.
- Exact system encodings: ecall 0x00000073, ebreak 0x00100073, mret 0x30200073.

Illegal instruction:
- Triggers: unlisted opcode/funct3/funct7; M encoding with HAS_M=0; RV32E=1 and a used register index has bit 4 set.
- Entry stores illegal=1 with rf_wr_en, csr_wr_en, do_jump, br_type, dm_rd_sel, dm_wr_sel all 0.

FIFO:
- Push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- Push and pop in the same cycle are both allowed: count unchanged, pointers both advance and wrap modulo DEPTH.
- in_ready = (count != DEPTH), registered-derived; there is no combinational path from out_ready.
- Latency: an instruction accepted at edge N is visible at out_* after edge N (one cycle minimum).
- Full: in_ready=0; in_valid is ignored with no overwrite.
- Empty: out_valid=0 and every out_* field is driven 0.
- Order is strictly FIFO.

Flush:
- On the next edge count becomes 0 and pointers reset.
- A same-cycle push and pop are both discarded.

Reset (asynchronous assert, synchronous-safe deassert):
- count=0, pointers 0, out_valid=0, all out_* = 0, in_ready=1.
- Reset asserted mid-stream discards all entries immediately.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → one cycle later out_valid=1, alu_ctrl=0, imm=5, rd=1, rf_wr_sel=2, rf_wr_en=1, illegal=0.
- Hold out_ready=0, push 3 instructions with DEPTH=2 → in_ready drops after 2nd push, count=2, 3rd not accepted; release out_ready → order preserved.
- Push and pop simultaneously with count=1 → count stays 1 across 10 back-to-back beats, pointers wrap correctly.
- mul x3,x1,x2 (0x022081B3): HAS_M=1 → alu_ctrl=16; HAS_M=0 → illegal=1, rf_wr_en=0.
- RV32E=1, add x16,x1,x2 (0x00208833) → illegal=1; ebreak (0x00100073) → is_ebreak=1, rf_wr_en=0.
- Fill FIFO, assert flush with in_valid=1 → next cycle count=0, out_valid=0; assert rst_n=0 mid-stream → outputs 0 asynchronously.
